// File: rtl/adder_check_pkg.sv
// Shared constants for the adder sweep checker: FSM encoding and settle bounds.
package adder_check_pkg;

  // Largest supported settle delay and the timer width that holds it.
  localparam int SETTLE_MAX = 15;
  localparam int TIMER_W    = 4;

  // FSM encoding kept as plain constants so older blocks can share it.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Timer preload: it counts load..0, so SETTLE lasts exactly 'cycles' cycles.
  function automatic logic [TIMER_W-1:0] settle_load(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/adder_sweep_checker_settle_timer.sv
// Loadable down-counter with a zero flag; times the operand settle window.
module settle_timer
  import adder_check_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; decrement only while nonzero so the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/adder_sweep_checker.sv
// Exhaustive sweep of an external WIDTH-bit adder: drive every (a,b) pair,
// wait SETTLE_CYCLES, compare against a+b with carry, and tally mismatches.
module adder_sweep_checker
  import adder_check_pkg::*;
#(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   adder_a,
  output logic [WIDTH-1:0]   adder_b,
  input  logic [WIDTH:0]     adder_sum,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   error_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  // One spare index bit so the counter can never wrap back into the sweep.
  localparam int              IW   = 2*WIDTH + 1;
  localparam logic [IW-1:0]   LAST = {1'b0, {(2*WIDTH){1'b1}}};

  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic          tmr_zero;
  logic          sum_ok;

  // Reference sum is taken from the registered operands, carry included.
  assign sum_ok = (adder_sum == ({1'b0, adder_a} + {1'b0, adder_b}));

  settle_timer #(.W(TIMER_W)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ST_DRIVE),
    .load_val (settle_load(SETTLE_CYCLES)),
    .dec      (state == ST_SETTLE),
    .zero     (tmr_zero)
  );

  // Sweep FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      adder_a     <= '0;
      adder_b     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      error_count <= '0;
      fail_a      <= '0;
      fail_b      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_DRIVE;
            idx         <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            error_count <= '0;
            fail_a      <= '0;
            fail_b      <= '0;
          end
        end
        ST_DRIVE: begin
          adder_a <= idx[WIDTH-1:0];
          adder_b <= idx[2*WIDTH-1:WIDTH];
          state   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (tmr_zero) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (!sum_ok) begin
            error_count <= error_count + 1'b1;
            if (error_count == '0) begin
              fail_a <= adder_a;
              fail_b <= adder_b;
            end
          end
          if (idx == LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= sum_ok && (error_count == '0);
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Directed bench: behavioural adders (correct, carry stuck low, off-by-one)
// feed two checker instances (SETTLE_CYCLES of 1 and 3).
module tb_adder_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  int         mode = 0;

  logic [2:0] a1, b1, fa1, fb1;
  logic [3:0] sum1;
  logic       busy1, done1, pass1;
  logic [6:0] ec1;

  logic [2:0] a2, b2, fa2, fb2;
  logic [3:0] sum2;
  logic       busy2, done2, pass2;
  logic [6:0] ec2;

  int total = 0;
  int bad   = 0;
  int cyc;
  bit busy_ok;

  always #5 clk = ~clk;

  // Adder under test for instance 1, behaviour selected by 'mode'.
  always_comb begin
    logic [3:0] full;
    full = {1'b0, a1} + {1'b0, b1};
    case (mode)
      1:       sum1 = {1'b0, full[2:0]};
      2:       sum1 = full + 4'd1;
      default: sum1 = full;
    endcase
  end

  assign sum2 = {1'b0, a2} + {1'b0, b2};

  adder_sweep_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .adder_a(a1), .adder_b(b1), .adder_sum(sum1),
    .busy(busy1), .done(done1), .pass(pass1),
    .error_count(ec1), .fail_a(fa1), .fail_b(fb1)
  );

  adder_sweep_checker #(.WIDTH(3), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .adder_a(a2), .adder_b(b2), .adder_sum(sum2),
    .busy(busy2), .done(done2), .pass(pass2),
    .error_count(ec2), .fail_a(fa2), .fail_b(fb2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start on instance 1 and count cycles from the first DRIVE cycle
  // until done. A second start pulse at cycle 'poke' must be ignored.
  task automatic sweep1(input int poke, output int n, output bit bz);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n  = 0;
    bz = 1'b1;
    while (!done1 && n < 2000) begin
      if (!busy1) bz = 1'b0;
      start = (n == poke);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
  endtask

  task automatic wait_done2(output int n);
    n = 0;
    while (!done2 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_ec", ec1, 0);
    chk("rst_ab", {a1, b1}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy1, 0);

    // Correct adder: 64 vectors * 3 cycles.
    mode = 0;
    sweep1(-1, cyc, busy_ok);
    chk("ok_cycles", cyc, 192);
    chk("ok_busy_held", busy_ok, 1);
    chk("ok_busy_end", busy1, 0);
    chk("ok_pass", pass1, 1);
    chk("ok_ec", ec1, 0);
    chk("ok_fail_ab", {fa1, fb1}, 0);
    chk("ok_last_ab", {a1, b1}, {3'd7, 3'd7});

    // Carry stuck low: 28 pairs with a+b>=8. Sweep order puts a in the low
    // index bits, so the first failing vector is index 15: a=7, b=1.
    mode = 1;
    sweep1(-1, cyc, busy_ok);
    chk("c0_cycles", cyc, 192);
    chk("c0_ec", ec1, 28);
    chk("c0_fail_a", fa1, 7);
    chk("c0_fail_b", fb1, 1);
    chk("c0_pass", pass1, 0);
    chk("c0_done", done1, 1);

    // Off by one everywhere: all 64 fail, first is index 0.
    mode = 2;
    sweep1(-1, cyc, busy_ok);
    chk("p1_ec", ec1, 64);
    chk("p1_fail_ab", {fa1, fb1}, 0);
    chk("p1_pass", pass1, 0);

    // Reset mid-sweep, after vector 15 has already been logged as a failure.
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("mid_ec", ec1, 1);
    chk("mid_fail_a", fa1, 7);
    chk("mid_busy", busy1, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", busy1, 0);
    chk("ar_done", done1, 0);
    chk("ar_pass", pass1, 0);
    chk("ar_ec", ec1, 0);
    chk("ar_fail_ab", {fa1, fb1}, 0);
    chk("ar_ab", {a1, b1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh full sweep after reset; a start pulse mid-run is ignored.
    mode = 0;
    sweep1(100, cyc, busy_ok);
    chk("rs_cycles", cyc, 192);
    chk("rs_busy_held", busy_ok, 1);
    chk("rs_pass", pass1, 1);

    // SETTLE_CYCLES=3, start held high: 64*5 cycles per sweep, one sweep
    // per entry into DONE.
    start2 = 1'b1;
    @(posedge clk); #1;
    chk("s3_busy_start", busy2, 1);
    wait_done2(cyc);
    chk("s3_cycles", cyc, 320);
    chk("s3_pass", pass2, 1);
    @(posedge clk); #1;
    chk("s3_restart_done", done2, 0);
    chk("s3_restart_busy", busy2, 1);
    wait_done2(cyc);
    chk("s3_cycles2", cyc, 320);
    chk("s3_ec", ec2, 0);
    start2 = 1'b0;
    @(posedge clk); #1;
    chk("s3_hold_done", done2, 1);
    chk("s3_hold_busy", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
